// File: rtl/price_window_writer_if.sv
// price_window_writer_if
//   Bundles the top-of-book update stream into the writer and the write beat
//   it produces for the volatility memory.
//   Update side : i_valid, i_stock_id, i_best_bid, i_best_ask
//   Beat side   : o_valid, o_write_address, o_stock_id, o_best_bid, o_best_ask,
//                 o_buffer_size, o_buffer_size_reciprocal
//   Status      : o_window_full (per stock), o_drop_count
//   master : the environment (drives updates, observes beats and status)
//   slave  : the writer itself
interface price_window_writer_if #(
  parameter int unsigned FP_WORD_SIZE = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_SIZE  = 32,
  parameter int unsigned NUM_STOCKS   = 4
);
  localparam int unsigned SW = $clog2(NUM_STOCKS);
  localparam int unsigned AW = $clog2(NUM_STOCKS * BUFFER_SIZE);

  logic                    i_valid;
  logic [SW-1:0]           i_stock_id;
  logic [DATA_WIDTH-1:0]   i_best_bid;
  logic [DATA_WIDTH-1:0]   i_best_ask;

  logic                    o_valid;
  logic [AW-1:0]           o_write_address;
  logic [SW-1:0]           o_stock_id;
  logic [DATA_WIDTH-1:0]   o_best_bid;
  logic [DATA_WIDTH-1:0]   o_best_ask;
  logic [DATA_WIDTH-1:0]   o_buffer_size;
  logic [FP_WORD_SIZE-1:0] o_buffer_size_reciprocal;
  logic [NUM_STOCKS-1:0]   o_window_full;
  logic [DATA_WIDTH-1:0]   o_drop_count;

  modport master (
    output i_valid, i_stock_id, i_best_bid, i_best_ask,
    input  o_valid, o_write_address, o_stock_id, o_best_bid, o_best_ask,
           o_buffer_size, o_buffer_size_reciprocal, o_window_full, o_drop_count
  );

  modport slave (
    input  i_valid, i_stock_id, i_best_bid, i_best_ask,
    output o_valid, o_write_address, o_stock_id, o_best_bid, o_best_ask,
           o_buffer_size, o_buffer_size_reciprocal, o_window_full, o_drop_count
  );
endinterface

// File: rtl/price_window_writer.sv
// price_window_writer
//   Write-side controller for the per-stock rolling price windows. Accepts
//   top-of-book updates, drops zero-priced or crossed quotes, and keeps a
//   circular write pointer and fill count per stock. Every accepted update
//   produces a one-cycle write beat carrying the flat buffer address
//   {stock, wr_ptr}, the quote, the window length including this sample and
//   floor(2^32 / length) in Q32.32.
// Ports
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus        : price_window_writer_if.slave (updates in, beats/status out)
module price_window_writer #(
  parameter int unsigned FP_WORD_SIZE = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_SIZE  = 32,
  parameter int unsigned NUM_STOCKS   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  price_window_writer_if.slave bus
);

  localparam int unsigned SW = $clog2(NUM_STOCKS);
  localparam int unsigned PW = $clog2(BUFFER_SIZE);
  localparam int unsigned FW = PW + 1;
  localparam int unsigned AW = SW + PW;
  localparam logic [FW-1:0] FILL_MAX = FW'(BUFFER_SIZE);

  function automatic logic [FP_WORD_SIZE-1:0] recip_of(input int unsigned n);
    logic [63:0] q;
    q = 64'h1_0000_0000 / 64'(n);
    return FP_WORD_SIZE'(q);
  endfunction

  // Entry i holds floor(2^32 / (i+1)); lengths run 1..BUFFER_SIZE so the
  // table is addressed with length-1 to keep it at BUFFER_SIZE entries.
  logic [FP_WORD_SIZE-1:0] recip_rom [BUFFER_SIZE];

  for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_rom
    localparam logic [FP_WORD_SIZE-1:0] RECIP = recip_of(i + 1);
    assign recip_rom[i] = RECIP;
  end

  logic [PW-1:0] wr_ptr [NUM_STOCKS];
  logic [FW-1:0] fill   [NUM_STOCKS];

  logic                    accept;
  logic                    reject;
  logic [SW-1:0]           sid;
  logic [PW-1:0]           cur_ptr;
  logic [FW-1:0]           cur_fill;
  logic [FW-1:0]           fill_next;
  logic [AW-1:0]           wr_addr;
  logic [FP_WORD_SIZE-1:0] recip_next;

  always_comb begin
    sid      = bus.i_stock_id;
    cur_ptr  = wr_ptr[sid];
    cur_fill = fill[sid];
    accept   = bus.i_valid
            && (bus.i_best_bid != '0)
            && (bus.i_best_ask != '0)
            && (bus.i_best_bid <= bus.i_best_ask);
    reject   = bus.i_valid && !accept;
    // Once full, the length stays at BUFFER_SIZE: each write replaces the
    // oldest sample.
    fill_next  = (cur_fill == FILL_MAX) ? cur_fill : cur_fill + FW'(1);
    wr_addr    = {sid, cur_ptr};
    recip_next = recip_rom[PW'(fill_next - FW'(1))];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
        wr_ptr[s] <= '0;
        fill[s]   <= '0;
      end
    end else if (accept) begin
      // Pointer wraps naturally: BUFFER_SIZE is a power of two.
      wr_ptr[sid] <= cur_ptr + PW'(1);
      fill[sid]   <= fill_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_valid                  <= 1'b0;
      bus.o_write_address          <= '0;
      bus.o_stock_id               <= '0;
      bus.o_best_bid               <= '0;
      bus.o_best_ask               <= '0;
      bus.o_buffer_size            <= '0;
      bus.o_buffer_size_reciprocal <= '0;
    end else begin
      bus.o_valid <= accept;
      // Data fields hold between beats; consumers qualify on o_valid.
      if (accept) begin
        bus.o_write_address          <= wr_addr;
        bus.o_stock_id               <= sid;
        bus.o_best_bid               <= bus.i_best_bid;
        bus.o_best_ask               <= bus.i_best_ask;
        bus.o_buffer_size            <= DATA_WIDTH'(fill_next);
        bus.o_buffer_size_reciprocal <= recip_next;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_window_full <= '0;
      bus.o_drop_count  <= '0;
    end else begin
      // Sticky: only reset clears a full window.
      if (accept && (fill_next == FILL_MAX)) begin
        bus.o_window_full[sid] <= 1'b1;
      end
      if (reject && (bus.o_drop_count != '1)) begin
        bus.o_drop_count <= bus.o_drop_count + DATA_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_price_window_writer.sv
// tb_price_window_writer
//   Directed bench for price_window_writer with hand-computed expectations.
module tb_price_window_writer;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  price_window_writer_if #(
    .FP_WORD_SIZE(64),
    .DATA_WIDTH  (32),
    .BUFFER_SIZE (32),
    .NUM_STOCKS  (4)
  ) bus ();

  price_window_writer #(
    .FP_WORD_SIZE(64),
    .DATA_WIDTH  (32),
    .BUFFER_SIZE (32),
    .NUM_STOCKS  (4)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one update for one cycle; returns #1 after the sampling edge.
  task automatic send(input logic [1:0] sid, input logic [31:0] bid, input logic [31:0] ask);
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_stock_id = sid;
    bus.i_best_bid = bid;
    bus.i_best_ask = ask;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] addr,
                            input logic [63:0] size, input logic [63:0] recip);
    check({tag, ".valid"}, 64'(bus.o_valid), 64'd1);
    check({tag, ".addr"},  64'(bus.o_write_address), addr);
    check({tag, ".size"},  64'(bus.o_buffer_size), size);
    check({tag, ".recip"}, bus.o_buffer_size_reciprocal, recip);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, ".addr"},  64'(bus.o_write_address), 64'd0);
    check({tag, ".sid"},   64'(bus.o_stock_id), 64'd0);
    check({tag, ".bid"},   64'(bus.o_best_bid), 64'd0);
    check({tag, ".ask"},   64'(bus.o_best_ask), 64'd0);
    check({tag, ".size"},  64'(bus.o_buffer_size), 64'd0);
    check({tag, ".recip"}, bus.o_buffer_size_reciprocal, 64'd0);
    check({tag, ".full"},  64'(bus.o_window_full), 64'd0);
    check({tag, ".drop"},  64'(bus.o_drop_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_size;
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_stock_id = '0;
    bus.i_best_bid = '0;
    bus.i_best_ask = '0;

    do_reset();

    // First beat on stock 2, then an idle cycle, then stock 2 again to
    // confirm wr_ptr[2]=1 and fill[2]=1.
    send(2'd2, 32'd100, 32'd102);
    check_beat("s2_first", 64'd64, 64'd1, 64'h1_0000_0000);
    check("s2_first.sid", 64'(bus.o_stock_id), 64'd2);
    check("s2_first.bid", 64'(bus.o_best_bid), 64'd100);
    check("s2_first.ask", 64'(bus.o_best_ask), 64'd102);
    idle();
    check("s2_idle.valid", 64'(bus.o_valid), 64'd0);
    check("s2_idle.hold_addr", 64'(bus.o_write_address), 64'd64);
    send(2'd2, 32'd101, 32'd103);
    check_beat("s2_second", 64'd65, 64'd2, 64'h8000_0000);

    // Three back-to-back updates on stock 1.
    send(2'd1, 32'd10, 32'd11);
    check_beat("s1_b1", 64'd32, 64'd1, 64'h1_0000_0000);
    send(2'd1, 32'd10, 32'd12);
    check_beat("s1_b2", 64'd33, 64'd2, 64'h8000_0000);
    send(2'd1, 32'd10, 32'd13);
    check_beat("s1_b3", 64'd34, 64'd3, 64'h5555_5555);

    // 33 updates on stock 0: window fills on beat 32, beat 33 wraps.
    for (int i = 0; i < 33; i++) begin
      send(2'd0, 32'(200 + i), 32'(300 + i));
      exp_size = (i < 32) ? 64'(i + 1) : 64'd32;
      check_beat($sformatf("s0_b%0d", i + 1), 64'(i % 32), exp_size,
                 64'h1_0000_0000 / exp_size);
      check($sformatf("s0_b%0d.full", i + 1), 64'(bus.o_window_full),
            (i >= 31) ? 64'd1 : 64'd0);
    end
    check("s0_b32_recip_const", 64'h1_0000_0000 / 64'd32, 64'h0800_0000);

    // Rejects: crossed book, zero bid, zero ask. Equal bid/ask is accepted.
    send(2'd1, 32'd105, 32'd104);
    check("drop1.valid", 64'(bus.o_valid), 64'd0);
    check("drop1.count", 64'(bus.o_drop_count), 64'd1);
    send(2'd1, 32'd0, 32'd50);
    check("drop2.valid", 64'(bus.o_valid), 64'd0);
    check("drop2.count", 64'(bus.o_drop_count), 64'd2);
    send(2'd1, 32'd60, 32'd61);
    check_beat("after_drop_s1", 64'd35, 64'd4, 64'h4000_0000);
    send(2'd2, 32'd50, 32'd0);
    check("drop3.valid", 64'(bus.o_valid), 64'd0);
    check("drop3.count", 64'(bus.o_drop_count), 64'd3);
    send(2'd2, 32'd7, 32'd7);
    check_beat("equal_s2", 64'd66, 64'd3, 64'h5555_5555);
    check("equal_s2.drop", 64'(bus.o_drop_count), 64'd3);
    idle();
    check("idle.drop", 64'(bus.o_drop_count), 64'd3);

    // Fresh state, then interleave stocks 0,3,0,3.
    do_reset();
    send(2'd0, 32'd1, 32'd2);
    check_beat("il_0a", 64'd0, 64'd1, 64'h1_0000_0000);
    send(2'd3, 32'd1, 32'd2);
    check_beat("il_3a", 64'd96, 64'd1, 64'h1_0000_0000);
    check("il_3a.sid", 64'(bus.o_stock_id), 64'd3);
    send(2'd0, 32'd1, 32'd2);
    check_beat("il_0b", 64'd1, 64'd2, 64'h8000_0000);
    send(2'd3, 32'd1, 32'd2);
    check_beat("il_3b", 64'd97, 64'd2, 64'h8000_0000);

    // Reset mid-stream: asserted between edges while i_valid stays high.
    send(2'd0, 32'd5, 32'd6);
    check_beat("pre_rst", 64'd2, 64'd3, 64'h5555_5555);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("mid_rst_hold");
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n       = 1'b1;
    send(2'd0, 32'd8, 32'd9);
    check_beat("post_rst", 64'd0, 64'd1, 64'h1_0000_0000);
    idle();
    check("post_rst_idle.valid", 64'(bus.o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
